sync_fifo_reader: RTL and testbench

//  Read-side master for sync_fifo. Drives the FIFO pop port (rd_en/dout/empty) and

---
 rtl/sync_fifo_reader.sv | 64 ++++++
 tb/tb_sync_fifo_reader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: pops sync_fifo into a valid/ready stream.
// A 2-entry skid buffer hides the FIFO's registered read latency, and an optional beat counter drives m_last.
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 0
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  sclr_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);
    localparam int BW = BURST_LEN > 0 ? $clog2(BURST_LEN + 1) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN > 0 ? BURST_LEN - 1 : 0);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head, tail, inflight, en, pop;
    logic [1:0]            cnt, occ_eff;
    logic [BW-1:0]         beat_cnt;

    assign pop        = m_valid && m_ready;
    assign occ_eff    = cnt + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd_en = en && !fifo_empty && occ_eff < 2'd2 && sclr_n;
    assign m_valid    = cnt != 2'd0;
    assign m_data     = mem[head];
    assign m_last     = BURST_LEN > 0 && m_valid && beat_cnt == LAST;
    assign busy       = m_valid || inflight;

    // en holds off popping for one cycle after async reset release
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mem      <= '{default: '0};
            head     <= 1'b0;
            tail     <= 1'b0;
            cnt      <= 2'd0;
            inflight <= 1'b0;
            beat_cnt <= '0;
            en       <= 1'b0;
        end else begin
            en <= 1'b1;
            if (!sclr_n) begin
                mem      <= '{default: '0};
                head     <= 1'b0;
                tail     <= 1'b0;
                cnt      <= 2'd0;
                inflight <= 1'b0;
                beat_cnt <= '0;
            end else begin
                if (inflight) mem[tail] <= fifo_dout;
                tail     <= tail ^ inflight;
                head     <= head ^ pop;
                cnt      <= cnt + {1'b0, inflight} - {1'b0, pop};
                inflight <= fifo_rd_en;
                if (pop && BURST_LEN > 0) beat_cnt <= beat_cnt == LAST ? '0 : beat_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: queue-based model of the reader plus a FIFO model, random and directed stimulus.
module tb_sync_fifo_reader;
    logic       clk = 0, aclr_n = 0, sclr_n = 1, m_ready = 0;
    logic       fifo_empty, fifo_rd_en, m_valid, m_last, busy;
    logic [7:0] fifo_dout = '0, m_data;

    logic [7:0]  fmem [256];
    int unsigned wp = 0, rp = 0;
    int          n_cmp = 0, n_err = 0, cyc = 0, rd_cnt = 0;

    logic [7:0] mq[$], log_d[$];
    logic [7:0] minfw;
    bit         log_l[$];
    int         log_c[$];
    bit         minf = 0, men = 0;
    int         beats = 0;

    assign fifo_empty = (wp == rp);

    sync_fifo_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en && wp != rp) begin
            fifo_dout <= fmem[rp[7:0]];
            rp <= rp + 1;
        end else if (!sclr_n) rp <= wp;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // model: words owned by the reader are a queue, plus one in-flight word from the last pop
    always @(negedge clk) begin
        bit ev, pop, er;
        if (!aclr_n) begin
            mq.delete(); minf = 0; beats = 0; men = 0;
        end
        ev  = mq.size() != 0;
        pop = ev && m_ready;
        er  = men && (wp != rp) && (int'(mq.size()) + int'(minf) - int'(pop) < 2) && sclr_n;
        chk("m_valid", m_valid, ev);
        chk("busy", busy, ev || minf);
        chk("fifo_rd_en", fifo_rd_en, er);
        chk("m_last", m_last, ev && (beats % 4 == 3));
        if (ev) chk("m_data", m_data, mq[0]);
        if (m_valid && m_ready) begin
            log_d.push_back(m_data); log_l.push_back(m_last); log_c.push_back(cyc);
        end
        if (fifo_rd_en) rd_cnt++;
        cyc++;
        if (aclr_n) begin
            men = 1;
            if (!sclr_n) begin
                mq.delete(); minf = 0; beats = 0;
            end else begin
                if (pop) begin void'(mq.pop_front()); beats++; end
                if (minf) mq.push_back(minfw);
                minf = er;
                if (er) minfw = fmem[rp[7:0]];
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic push(input logic [7:0] d); fmem[wp[7:0]] = d; wp++; endtask
    task automatic clr_logs(); log_d.delete(); log_l.delete(); log_c.delete(); rd_cnt = 0; endtask
    task automatic drain();
        for (int k = 0; k < 300 && !(wp == rp && !busy); k++) tick();
        chk("drain_done", (wp == rp && !busy), 1);
    endtask

    initial begin
        repeat (2) tick();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        m_ready = 1;
        tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        aclr_n = 1;
        clr_logs();
        chk("rel_rd_en_now", fifo_rd_en, 0);
        tick();
        chk("rel_rd_en_next", fifo_rd_en, 1);
        drain();
        chk("stream_beats", log_d.size(), 8);
        chk("stream_rd_cnt", rd_cnt, 8);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("stream_data", log_d[i], 8'h10 + 8'(i));
            chk("stream_no_bubble", log_c[7] - log_c[0], 7);
            chk("stream_last3", log_l[3], 1);
            chk("stream_last7", log_l[7], 1);
            chk("stream_last0", log_l[0], 0);
        end

        m_ready = 0;
        clr_logs();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        m_ready = 1;
        for (int k = 0; k < 20 && !m_valid; k++) tick();
        chk("bp_first_valid", m_valid, 1);
        tick();
        m_ready = 0;
        repeat (5) tick();
        chk("bp_hold_data", m_data, 8'h11);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_rd_en", fifo_rd_en, 0);
        chk("bp_busy", busy, 1);
        m_ready = 1;
        drain();
        chk("bp_beats", log_d.size(), 8);
        if (log_d.size() == 8)
            for (int i = 0; i < 8; i++) chk("bp_data", log_d[i], 8'h10 + 8'(i));

        clr_logs();
        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        drain();
        chk("burst_beats", log_d.size(), 10);
        if (log_d.size() == 10)
            for (int i = 0; i < 10; i++) chk("burst_last", log_l[i], (i == 3 || i == 7));

        clr_logs();
        push(8'h40); push(8'h41); push(8'h42);
        repeat (8) tick();
        chk("gap_m_valid", m_valid, 0);
        chk("gap_rd_en", fifo_rd_en, 0);
        push(8'h43); push(8'h44);
        drain();
        chk("under_beats", log_d.size(), 5);
        if (log_d.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk("under_data", log_d[i], 8'h40 + 8'(i));
                chk("under_last", log_l[i], i == 1);
            end

        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        repeat (4) tick();
        chk("clr_pre_busy", busy, 1);
        sclr_n = 0;
        tick();
        sclr_n = 1;
        clr_logs();
        chk("clr_m_valid", m_valid, 0);
        chk("clr_busy", busy, 0);
        push(8'hAA); push(8'hAB); push(8'hAC); push(8'hAD);
        drain();
        chk("clr_beats", log_d.size(), 4);
        if (log_d.size() == 4) begin
            chk("clr_first", log_d[0], 8'hAA);
            for (int i = 0; i < 4; i++) chk("clr_last", log_l[i], i == 3);
        end

        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0) ? (i % 400 < 300) : 1'b0;
            sclr_n  = ($urandom_range(0, 96) != 0);
            aclr_n  = !(i == 1500);
            if (wp - rp < 16 && $urandom_range(0, 1) == 1) push(8'($urandom));
            tick();
        end
        aclr_n = 1; sclr_n = 1; m_ready = 1;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
